fetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the synchronous instruction memory.
- Holds the fetch PC and presents `iaddr` to the memory.
- Consumes `idata` one cycle later and delivers {pc, ins} to decode through a valid/ready handshake.
- Handles backpressure, branch redirects and misaligned-PC faults; sits between the instruction memory and the decode stage of the CPU core.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 84 ++++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and types for the instruction-fetch block.
//   ADDR_W        - byte-address width of the fetch PC / iaddr
//   DATA_W        - instruction width
//   fetch_state_t - fetch FSM state (RUN, FAULT)
//   fetch_entry_t - {pc, ins} pair handed to decode
package fetch_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: two-entry fetch buffer made of the decode-facing output register plus
// one skid entry, so a word already in flight when decode stalls is never dropped.
//   clk_i         - clock, rising edge
//   rst_i         - asynchronous active-high reset
//   push_i        - an arriving entry is presented this cycle
//   push_entry_i  - the arriving {pc, ins}
//   pop_i         - decode ready; a pop occurs when out_valid_o && pop_i
//   flush_i       - discard everything buffered (arriving entry included)
//   out_valid_o   - output register holds a valid entry
//   out_entry_o   - output register contents
//   occupancy_o   - number of valid entries held (output + skid)
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         out_valid_o,
    output fetch_entry_t out_entry_o,
    output logic [1:0]   occupancy_o
);

    logic         out_valid_q, out_valid_d;
    fetch_entry_t out_entry_q, out_entry_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t skid_entry_q, skid_entry_d;

    logic out_free;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_entry_d  = out_entry_q;
        skid_valid_d = skid_valid_q;
        skid_entry_d = skid_entry_q;
        // Output register can take a new entry if it is empty or drains this cycle.
        out_free     = !out_valid_q || pop_i;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry moves forward; the arrival takes its place.
                out_valid_d  = 1'b1;
                out_entry_d  = skid_entry_q;
                skid_valid_d = push_i;
                if (push_i) begin
                    skid_entry_d = push_entry_i;
                end
            end else begin
                out_valid_d = push_i;
                if (push_i) begin
                    out_entry_d = push_entry_i;
                end
            end
        end else if (push_i) begin
            // The issue rule keeps the skid empty whenever this path is taken.
            skid_valid_d = 1'b1;
            skid_entry_d = push_entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_entry_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_entry_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_entry_q  <= out_entry_d;
            skid_valid_q <= skid_valid_d;
            skid_entry_q <= skid_entry_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_entry_o = out_entry_q;
    assign occupancy_o = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator. Holds the fetch PC, issues one word per cycle to a
// synchronous 1-cycle-latency instruction memory, and delivers {pc, ins} to decode through
// a valid/ready handshake. Handles backpressure, branch redirects and misaligned-PC faults.
//   clk_i            - clock, rising edge
//   rst_i            - asynchronous active-high reset
//   en_i             - run enable; no new fetches while low
//   iaddr_o          - byte address to instruction memory (= pc_q)
//   idata_i          - memory read data for the address presented at the previous edge
//   redirect_valid_i - one-cycle branch/jump redirect request
//   redirect_pc_i    - redirect target
//   out_valid_o      - decode entry valid
//   out_ins_o        - instruction
//   out_pc_o         - address of out_ins_o
//   out_ready_i      - decode accepts when out_valid_o && out_ready_i at an edge
//   fault_o          - sticky misaligned-fetch fault
module fetch_unit #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] iaddr_o,
    input  logic [DATA_W-1:0] idata_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_ins_o,
    output logic [ADDR_W-1:0] out_pc_o,
    input  logic              out_ready_i,
    output logic              fault_o
);

    import fetch_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic         redirect;
    logic         pop;
    logic         misaligned;
    logic         issue;
    logic         fault_set;
    logic [2:0]   occ;
    logic [1:0]   buf_occ;
    logic         buf_out_valid;
    fetch_entry_t buf_out_entry;
    fetch_entry_t arrival;

    always_comb begin
        redirect   = redirect_valid_i && (state_q == RUN);
        pop        = buf_out_valid && out_ready_i;
        misaligned = (pc_q[1:0] != 2'b00);
        // Entries that will be held after this edge if nothing new is issued.
        occ        = {1'b0, buf_occ} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == RUN) && en_i && !redirect && !misaligned && (occ < 3'd2);
        fault_set  = (state_q == RUN) && en_i && !redirect && misaligned;

        arrival.pc  = inflight_pc_q;
        arrival.ins = idata_i;

        state_d       = fault_set ? FAULT : state_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        pc_d          = pc_q;
        if (redirect) begin
            pc_d = redirect_pc_i;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A redirect discards the in-flight word and everything buffered.
    fetch_skid_buf u_skid_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (inflight_q),
        .push_entry_i (arrival),
        .pop_i        (out_ready_i),
        .flush_i      (redirect),
        .out_valid_o  (buf_out_valid),
        .out_entry_o  (buf_out_entry),
        .occupancy_o  (buf_occ)
    );

    assign iaddr_o     = pc_q;
    assign out_valid_o = buf_out_valid;
    assign out_ins_o   = buf_out_entry.ins;
    assign out_pc_o    = buf_out_entry.pc;
    assign fault_o     = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle registered memory model
// where mem[i] = 0x1000_0000 + i (i is the word index).
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [5:0]  iaddr_o;
    logic [31:0] idata_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [5:0]  redirect_pc_i = '0;
    logic        out_valid_o;
    logic [31:0] out_ins_o;
    logic [5:0]  out_pc_o;
    logic        out_ready_i = 1'b0;
    logic        fault_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .RESET_PC (6'h00)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .en_i             (en_i),
        .iaddr_o          (iaddr_o),
        .idata_i          (idata_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .out_valid_o      (out_valid_o),
        .out_ins_o        (out_ins_o),
        .out_pc_o         (out_pc_o),
        .out_ready_i      (out_ready_i),
        .fault_o          (fault_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        idata_i <= 32'h1000_0000 + {28'd0, iaddr_o[5:2]};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] pc);
        check({tag, ".valid"}, 32'(out_valid_o), 32'd1);
        check({tag, ".pc"}, 32'(out_pc_o), 32'(pc));
        check({tag, ".ins"}, out_ins_o, 32'h1000_0000 + 32'(pc[5:2]));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.valid", 32'(out_valid_o), 32'd0);
        check("rst.ins", out_ins_o, 32'd0);
        check("rst.fault", 32'(fault_o), 32'd0);
        check("rst.iaddr", 32'(iaddr_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // 1. Streaming
        en_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        check("s1.valid_e1", 32'(out_valid_o), 32'd0);
        tick();
        check_out("s1.e2", 6'h00);
        tick();
        check_out("s1.e3", 6'h04);

        // 2. Backpressure: out holds pc 0x04, iaddr parks at 0x0C
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("bp.hold", 6'h04);
            check("bp.iaddr", 32'(iaddr_o), 32'h0C);
        end
        out_ready_i = 1'b1;
        tick();
        check_out("bp.r1", 6'h08);
        tick();
        check_out("bp.r2", 6'h0C);
        tick();
        check_out("bp.r3", 6'h10);

        // 3. Redirect to 0x20
        redirect_valid_i = 1'b1;
        redirect_pc_i = 6'h20;
        tick();
        redirect_valid_i = 1'b0;
        check("rd.valid0", 32'(out_valid_o), 32'd0);
        check("rd.iaddr", 32'(iaddr_o), 32'h20);
        tick();
        check("rd.valid1", 32'(out_valid_o), 32'd0);
        tick();
        check_out("rd.t0", 6'h20);
        tick();
        check_out("rd.t1", 6'h24);

        // 4. Misaligned redirect -> fault
        redirect_valid_i = 1'b1;
        redirect_pc_i = 6'h22;
        tick();
        redirect_valid_i = 1'b0;
        check("ft.valid0", 32'(out_valid_o), 32'd0);
        check("ft.fault0", 32'(fault_o), 32'd0);
        tick();
        check("ft.fault1", 32'(fault_o), 32'd1);
        check("ft.valid1", 32'(out_valid_o), 32'd0);
        check("ft.iaddr1", 32'(iaddr_o), 32'h22);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 6'h00;
        tick();
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ft.iaddr_ign", 32'(iaddr_o), 32'h22);
            check("ft.valid_ign", 32'(out_valid_o), 32'd0);
            check("ft.fault_sticky", 32'(fault_o), 32'd1);
            tick();
        end
        en_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("ft.rst_fault", 32'(fault_o), 32'd0);
        check("ft.rst_iaddr", 32'(iaddr_o), 32'h00);
        tick();
        rst_i = 1'b0;
        tick();

        // 5. Wrap: redirect to 0x3C
        en_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 6'h3C;
        tick();
        redirect_valid_i = 1'b0;
        check("wr.iaddr", 32'(iaddr_o), 32'h3C);
        tick();
        check("wr.iaddr_wrap", 32'(iaddr_o), 32'h00);
        tick();
        check_out("wr.t0", 6'h3C);
        tick();
        check_out("wr.t1", 6'h00);

        // 6. Fill both entries, then async reset mid-cycle
        out_ready_i = 1'b0;
        tick();
        check_out("ar.full", 6'h00);
        check("ar.iaddr_full", 32'(iaddr_o), 32'h08);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar.valid", 32'(out_valid_o), 32'd0);
        check("ar.ins", out_ins_o, 32'd0);
        check("ar.fault", 32'(fault_o), 32'd0);
        check("ar.iaddr", 32'(iaddr_o), 32'h00);
        en_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
